mag_sched: RTL

//  Round-robin scheduler sharing one root-sum-of-squares datapath (8b square -> 20b accumulate -> 10b DW_sqrt)

---
 rtl/mag_sched_pkg.sv | 11 +
 rtl/DW_sqrt.sv | 37 +++
 rtl/mag_sched_rr_arbiter.sv | 39 +++
 rtl/mag_sched.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mag_sched_pkg.sv
// Shared types and widths for the mag_sched root-sum-of-squares scheduler.
package mag_sched_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, SQRT, OUT} state_t;

  localparam int DATA_W = 8;
  localparam int SQ_W   = 16;
  localparam int ACC_W  = 20;
  localparam int ROOT_W = 10;

endpackage

// File: rtl/DW_sqrt.sv
// Combinational integer square root, root = floor(sqrt(a)); tc_mode!=0 takes |a| of a signed input.
module DW_sqrt #(
  parameter int width   = 8,
  parameter int tc_mode = 0
) (
  input  logic [width-1:0]         a,
  output logic [(width+1)/2-1:0]   root
);

  localparam int RW = (width + 1) / 2;

  logic [width-1:0]  mag;
  logic [2*RW-1:0]   mag_ext;
  logic [2*RW-1:0]   sq;
  logic [RW-1:0]     q;
  logic [RW-1:0]     trial;

  assign mag     = (tc_mode != 0 && a[width-1]) ? -a : a;
  assign mag_ext = (2*RW)'(mag);

  // Decide one root bit per step, MSB first, keeping it when trial^2 still fits.
  always_comb begin
    q     = '0;
    trial = '0;
    sq    = '0;
    for (int i = RW - 1; i >= 0; i--) begin
      trial = q | (RW'(1) << i);
      sq    = (2*RW)'(trial) * (2*RW)'(trial);
      if (sq <= mag_ext) begin
        q = trial;
      end
    end
  end

  assign root = q;

endmodule

// File: rtl/mag_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping; purely combinational.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]          req,
  input  logic [$clog2(NREQ)-1:0]  ptr,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  grant_idx,
  output logic                     any_req
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W:0] cand;

  // Scan from the farthest offset down so the nearest valid requester wins last.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      if (req[cand[IDX_W-1:0]]) begin
        grant_idx = cand[IDX_W-1:0];
        any_req   = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
      assign grant[gi] = any_req && (grant_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/mag_sched.sv
// Round-robin shared sum-of-squares + sqrt datapath; one requester owns it per frame.
// Optional MAG_SAT_EN: saturating accumulator with sticky per-frame out_sat flag.
module mag_sched
  import mag_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [DATA_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROOT_W-1:0]        out_root,
  output logic [$clog2(NREQ)-1:0]  out_id,
  output logic                     out_sat
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  grant_reg, ptr_reg, arb_idx;
  logic [NREQ-1:0]   grant_oh_reg, arb_oh;
  logic              arb_any;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ROOT_W-1:0] root_w;

  logic              sel_valid, sel_last, beat, close;
  logic [DATA_W-1:0] sel_data;
  logic [SQ_W-1:0]   sq;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (arb_oh),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  DW_sqrt #(.width(ACC_W), .tc_mode(0)) u_sqrt (
    .a    (acc_reg),
    .root (root_w)
  );

  assign sel_valid = req_valid[grant_reg];
  assign sel_last  = req_last[grant_reg];
  assign sel_data  = req_data[grant_reg*DATA_W +: DATA_W];
  assign beat      = (state_reg == ACCUM) && sel_valid;
  assign sq        = SQ_W'(sel_data) * SQ_W'(sel_data);
  assign close     = sel_last || (cnt_reg == CNT_W'(MAX_BEATS - 1));

  // Ready depends on state only, so a producer's valid never loops back into its ready.
  assign req_ready = (state_reg == ACCUM) ? grant_oh_reg : '0;
  assign out_valid = (state_reg == OUT);

`ifdef MAG_SAT_EN
  logic [ACC_W:0] sum_w;
  logic           sat_reg;

  assign sum_w    = {1'b0, acc_reg} + (ACC_W+1)'(sq);
  assign acc_next = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_reg <= 1'b0;
      out_sat <= 1'b0;
    end else begin
      if (state_reg == IDLE && arb_any) begin
        sat_reg <= 1'b0;
      end else if (beat) begin
        sat_reg <= sat_reg | sum_w[ACC_W];
      end
      if (state_reg == SQRT) begin
        out_sat <= sat_reg;
      end
    end
  end
`else
  assign acc_next = acc_reg + ACC_W'(sq);
  assign out_sat  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_any) state_next = ACCUM;
      ACCUM:   if (beat && close) state_next = SQRT;
      SQRT:    state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg      <= '0;
      grant_reg    <= '0;
      grant_oh_reg <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      out_root     <= '0;
      out_id       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            grant_reg    <= arb_idx;
            grant_oh_reg <= arb_oh;
            ptr_reg      <= (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            acc_reg      <= '0;
            cnt_reg      <= '0;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        SQRT: begin
          out_root <= root_w;
          out_id   <= grant_reg;
        end
        default: ;
      endcase
    end
  end

endmodule
